comparator_table_loader: RTL and testbench
==========================================

// Module: comparator_table_loader
// PURPOSE
//  Configuration controller for the Tanimoto comparator's threshold result RAM.
//  On request, it fills all VECTOR_WIDTH+1 entries with entry[c] = ceil(c*K/2^FRAC_W), where K is the threshold ratio.
//  It sequences the write pass and blocks the popcount datapath while the table is stale or being rewritten.
//  Sits between the wrapper's threshold port and the comparator's BRAM write port.
// PARAMETERS
//  VECTOR_WIDTH  920                         fingerprint bits; table depth = VECTOR_WIDTH+1
//  CNT_WIDTH     $clog2(VECTOR_WIDTH)        address width; entry width = CNT_WIDTH+1
//  FRAC_W        12                          fractional bits of ratio K
//  RATIO_W       16                          total width of K (unsigned fixed point)
//  DRAIN_CYCLES  2                           flush cycles before first write (>=1)
// PORTS
//  clk            in   1            single clock
//  rst            in   1            synchronous, active-high reset
//  i_CfgStart     in   1            request a table (re)load
//  i_CfgRatio     in   RATIO_W      K, sampled when the request is accepted
//  o_CfgBusy      out  1            high in DRAIN/LOAD/DONE
//  o_CfgDone      out  1            1-cycle pulse when the load completes
//  o_CfgDropped   out  1            sticky: start lost (feature off); cleared by rst
//  o_TableValid   out  1            table holds a completed load
//  o_BRAM_Addr    out  CNT_WIDTH    to comparator i_BRAM_Addr
//  o_BRAM_Din     out  CNT_WIDTH+1  to comparator i_BRAM_Din
//  o_BRAM_En      out  1            to comparator i_BRAM_En
//  o_BRAM_WrEn    out  1            to comparator i_BRAM_WrEn
//  i_DpValid      in   1            upstream popcount valid
//  o_DpReady      out  1            = o_TableValid & state==IDLE
//  o_DpValid      out  1            = i_DpValid & o_DpReady, to comparator i_Valid
// BEHAVIOUR
//  Reset values:
//   - All outputs are 0, except o_BRAM_En = 1 (comparator reads need the port enabled).
//   - State = IDLE; o_TableValid = 0.
//  FSM (IDLE -> DRAIN -> LOAD -> DONE -> IDLE):
//   - IDLE:  when i_CfgStart=1, latch K, clear o_TableValid, and go to DRAIN next cycle.
//   - DRAIN: run DRAIN_CYCLES cycles with o_DpReady=0 and no writes.
//   - LOAD:  run exactly VECTOR_WIDTH+1 cycles. Address c = 0..VECTOR_WIDTH, one write per cycle, o_BRAM_WrEn=1.
//   - DONE:  1 cycle. o_CfgDone=1, o_TableValid is set, then IDLE.
//  Latency: start to o_CfgDone = 1 + DRAIN_CYCLES + VECTOR_WIDTH+1 cycles.
//  Arithmetic (no multiplier):
//   - Accumulator is CNT_WIDTH+RATIO_W+1 bits and is initialised to 2^FRAC_W-1.
//   - Din = acc>>FRAC_W; add K after each write.
//   - Saturate Din to 2^(CNT_WIDTH+1)-1 when the shifted value overflows. Saturation is sticky for the rest of the pass.
//  Boundary conditions:
//   - K=0: every entry = 0.
//   - Address never exceeds VECTOR_WIDTH; no wrap-around.
//   - i_CfgStart while busy: handled by the CONFIGURATION feature.
//   - i_CfgStart in the DONE cycle counts as "while busy".
//   - Reset mid-load: IDLE, o_TableValid=0. The partially written table is not trusted.
//   - o_BRAM_Din is don't-care when o_BRAM_WrEn=0; it is driven 0.
// CONFIGURATION
//  Macro CMP_LOADER_CFG_QUEUE_EN:
//   - Defined: a 1-deep pending request register latches {start, ratio}.
//     A later request while pending overwrites it (last wins).
//     On DONE, a pending request goes straight to DRAIN without an IDLE cycle; o_CfgDone still pulses.
//     o_CfgDropped stays 0.
//   - Undefined: a start while busy is ignored and sets o_CfgDropped.
// STRUCTURE
//  Shared header comparator_cfg_defs.vh:
//   - FSM state localparams (2-bit).
//   - Entry-width and accumulator-width localparam expressions, shared with the comparator wrapper.
//  Sub-module threshold_accumulator:
//   - init/step controls plus K input; outputs the saturated entry.
//   - Holds the ceil-offset init and the sticky saturation flag.
// TESTING
//  1. Reset, then idle:
//     o_TableValid=0, o_DpReady=0, o_BRAM_WrEn=0.
//     i_DpValid=1 gives o_DpValid=0.
//  2. K=2.0 (0x2000), start:
//     busy next cycle; first write at cycle 1+DRAIN_CYCLES.
//     Writes entry[c]=2c for c=0..920 (entry[920]=1840).
//     Done pulse after 924 cycles total; o_TableValid=1.
//  3. K=0x1555 (~1.333), start:
//     entry[3]=4, entry[1]=2 (ceil); a scoreboard checks every entry.
//  4. K=3.0 (0x3000):
//     entry[682]=2046; entry[683..920]=2047 (saturated).
//  5. Assert rst at LOAD address 400:
//     next cycle IDLE, WrEn=0, o_TableValid=0.
//     A new start then performs a full 921-write load.
//  6. Start at LOAD address 100 with K2:
//     queue on  -> second load of K2 begins right after DONE.
//     queue off -> o_CfgDropped=1 and only one load occurs.

Source files
------------

// File: rtl/comparator_table_loader_pkg.sv
// Shared definitions for the Tanimoto comparator threshold-table loader.
// Holds the 2-bit FSM state encoding and the entry/accumulator width
// expressions that the comparator wrapper also uses to size its BRAM port.
// Optional feature macro: CMP_LOADER_CFG_QUEUE_EN (1-deep pending start request).
package comparator_table_loader_pkg;

    // Loader FSM states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // A table entry must hold counts up to VECTOR_WIDTH, one bit wider than the address
    function automatic int entry_width(input int cnt_w);
        return cnt_w + 1;
    endfunction

    // Accumulator wide enough for VECTOR_WIDTH * K_max plus the ceil offset
    function automatic int acc_width(input int cnt_w, input int ratio_w);
        return cnt_w + ratio_w + 1;
    endfunction

endpackage

// File: rtl/comparator_table_loader_threshold_accumulator.sv
// threshold_accumulator: multiplier-free generator of ceil(c*K/2^FRAC_W).
// The accumulator starts at 2^FRAC_W-1 so that a plain right shift yields the
// ceiling; each step adds K. The entry saturates at the all-ones value and the
// saturation is sticky until the next init.
// Optional feature macro (used by the top level): CMP_LOADER_CFG_QUEUE_EN.
module threshold_accumulator
    import comparator_table_loader_pkg::*;
#(
    parameter int CNT_WIDTH = 10,
    parameter int FRAC_W    = 12,
    parameter int RATIO_W   = 16
) (
    input  logic               clk,
    input  logic               init,
    input  logic               step,
    input  logic [RATIO_W-1:0] ratio,
    output logic [CNT_WIDTH:0] entry
);

    localparam int ACC_W   = acc_width(CNT_WIDTH, RATIO_W);
    localparam int ENTRY_W = entry_width(CNT_WIDTH);
    localparam int SH_W    = ACC_W - FRAC_W;
    localparam logic [ACC_W-1:0] CEIL_OFFSET = ACC_W'((1 << FRAC_W) - 1);

    logic [ACC_W-1:0] acc;
    logic             sat;
    logic [SH_W-1:0]  shifted;

    // True when the integer part no longer fits in an entry
    function automatic logic overflows(input logic [SH_W-1:0] s);
        return (s >> ENTRY_W) != '0;
    endfunction

    // Clamp the integer part to the largest representable entry
    function automatic logic [ENTRY_W-1:0] saturate(input logic [SH_W-1:0] s,
                                                    input logic sticky);
        if (sticky || overflows(s)) begin
            return {ENTRY_W{1'b1}};
        end
        return s[ENTRY_W-1:0];
    endfunction

    assign shifted = acc[ACC_W-1:FRAC_W];

    // Accumulate K once per written entry; init restarts the pass with the ceil offset
    always_ff @(posedge clk) begin
        if (init) begin
            acc <= CEIL_OFFSET;
            sat <= 1'b0;
        end else if (step) begin
            acc <= acc + ACC_W'(ratio);
            sat <= sat | overflows(shifted);
        end
    end

    assign entry = saturate(shifted, sat);

endmodule

// File: rtl/comparator_table_loader.sv
// comparator_table_loader: fills the comparator's threshold RAM with
// entry[c] = ceil(c*K/2^FRAC_W), c = 0..VECTOR_WIDTH, and holds off the
// popcount datapath while the table is stale or being rewritten.
// FSM: IDLE -> DRAIN -> LOAD -> DONE -> IDLE.
// Optional feature macro: CMP_LOADER_CFG_QUEUE_EN
//   defined   : a start while busy is held in a 1-deep pending register (last
//               request wins) and launched directly from DONE.
//   undefined : a start while busy is ignored and sets o_CfgDropped.
module comparator_table_loader
    import comparator_table_loader_pkg::*;
#(
    parameter int VECTOR_WIDTH = 920,
    parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
    parameter int FRAC_W       = 12,
    parameter int RATIO_W      = 16,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_CfgStart,
    input  logic [RATIO_W-1:0]   i_CfgRatio,
    output logic                 o_CfgBusy,
    output logic                 o_CfgDone,
    output logic                 o_CfgDropped,
    output logic                 o_TableValid,
    output logic [CNT_WIDTH-1:0] o_BRAM_Addr,
    output logic [CNT_WIDTH:0]   o_BRAM_Din,
    output logic                 o_BRAM_En,
    output logic                 o_BRAM_WrEn,
    input  logic                 i_DpValid,
    output logic                 o_DpReady,
    output logic                 o_DpValid
);

    localparam int ENTRY_W = entry_width(CNT_WIDTH);
    localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] LAST_ADDR  = CNT_WIDTH'(VECTOR_WIDTH);
    localparam logic [DRAIN_W-1:0]   LAST_DRAIN = DRAIN_W'(DRAIN_CYCLES - 1);

    logic [1:0]           state;
    logic [CNT_WIDTH-1:0] addr;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 table_valid;
    logic                 dropped;
    logic                 busy;
    logic                 accept;
    logic [RATIO_W-1:0]   accept_ratio;
    logic [RATIO_W-1:0]   ratio_q;
    logic                 loading;
    logic [ENTRY_W-1:0]   entry;

    assign busy    = (state != ST_IDLE);
    assign loading = (state == ST_LOAD);

`ifdef CMP_LOADER_CFG_QUEUE_EN
    logic               pend_vld;
    logic [RATIO_W-1:0] pend_ratio;

    // A fresh start in DONE overrides an older pending one (last request wins)
    always_comb begin
        accept       = 1'b0;
        accept_ratio = i_CfgRatio;
        if (state == ST_IDLE) begin
            accept = i_CfgStart;
        end else if (state == ST_DONE) begin
            accept       = i_CfgStart | pend_vld;
            accept_ratio = i_CfgStart ? i_CfgRatio : pend_ratio;
        end
    end

    // Pending flag: set by a start during DRAIN/LOAD, consumed in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld <= 1'b0;
        end else if (state == ST_DONE) begin
            pend_vld <= 1'b0;
        end else if (busy && i_CfgStart) begin
            pend_vld <= 1'b1;
        end
    end

    // Pending ratio tracks the most recent start seen during DRAIN/LOAD
    always_ff @(posedge clk) begin
        if (busy && (state != ST_DONE) && i_CfgStart) begin
            pend_ratio <= i_CfgRatio;
        end
    end

    assign dropped = 1'b0;
`else
    // Only an idle loader accepts a request
    always_comb begin
        accept       = (state == ST_IDLE) && i_CfgStart;
        accept_ratio = i_CfgRatio;
    end

    // Sticky record of a request that arrived while busy (DONE included)
    always_ff @(posedge clk) begin
        if (rst) begin
            dropped <= 1'b0;
        end else if (busy && i_CfgStart) begin
            dropped <= 1'b1;
        end
    end
`endif

    // Loader FSM: drain the datapath, write every entry once, then report completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            addr        <= '0;
            drain_cnt   <= '0;
            table_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state       <= ST_DRAIN;
                        drain_cnt   <= '0;
                        table_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        state <= ST_LOAD;
                        addr  <= '0;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Stop on the last entry so the address never wraps
                    if (addr == LAST_ADDR) begin
                        state <= ST_DONE;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end
                ST_DONE: begin
                    addr      <= '0;
                    drain_cnt <= '0;
                    if (accept) begin
                        // Back-to-back reload: the table goes stale again immediately
                        state       <= ST_DRAIN;
                        table_valid <= 1'b0;
                    end else begin
                        state       <= ST_IDLE;
                        table_valid <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Ratio for the pass, captured when the request is accepted
    always_ff @(posedge clk) begin
        if (accept) begin
            ratio_q <= accept_ratio;
        end
    end

    threshold_accumulator #(
        .CNT_WIDTH (CNT_WIDTH),
        .FRAC_W    (FRAC_W),
        .RATIO_W   (RATIO_W)
    ) u_acc (
        .clk   (clk),
        .init  (accept),
        .step  (loading),
        .ratio (ratio_q),
        .entry (entry)
    );

    assign o_CfgBusy    = busy;
    assign o_CfgDone    = (state == ST_DONE);
    assign o_CfgDropped = dropped;
    assign o_TableValid = table_valid;
    assign o_BRAM_Addr  = addr;
    assign o_BRAM_WrEn  = loading;
    assign o_BRAM_Din   = loading ? entry : '0;
    assign o_BRAM_En    = 1'b1;
    assign o_DpReady    = table_valid && (state == ST_IDLE);
    assign o_DpValid    = i_DpValid && o_DpReady;

endmodule

// File: tb/tb_comparator_table_loader.sv
// Self-checking bench for comparator_table_loader (default parameters).
// Expected entries come from ceil(c*K/4096) clamped to 2047, computed here
// with plain integer arithmetic; probe records hold hand-derived values.
// Optional feature macro: CMP_LOADER_CFG_QUEUE_EN selects the expected
// behaviour of the start-while-busy sequence.
module tb_comparator_table_loader;

    localparam int VW   = 920;
    localparam int CW   = 10;
    localparam int FW   = 12;
    localparam int RW   = 16;
    localparam int DC   = 2;
    localparam int EMAX = 2047;
    localparam int LAT  = 1 + DC + VW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_CfgStart;
    logic [RW-1:0] i_CfgRatio;
    logic          o_CfgBusy;
    logic          o_CfgDone;
    logic          o_CfgDropped;
    logic          o_TableValid;
    logic [CW-1:0] o_BRAM_Addr;
    logic [CW:0]   o_BRAM_Din;
    logic          o_BRAM_En;
    logic          o_BRAM_WrEn;
    logic          i_DpValid;
    logic          o_DpReady;
    logic          o_DpValid;

    always #5 clk = ~clk;

    comparator_table_loader #(
        .VECTOR_WIDTH (VW),
        .CNT_WIDTH    (CW),
        .FRAC_W       (FW),
        .RATIO_W      (RW),
        .DRAIN_CYCLES (DC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_CfgStart   (i_CfgStart),
        .i_CfgRatio   (i_CfgRatio),
        .o_CfgBusy    (o_CfgBusy),
        .o_CfgDone    (o_CfgDone),
        .o_CfgDropped (o_CfgDropped),
        .o_TableValid (o_TableValid),
        .o_BRAM_Addr  (o_BRAM_Addr),
        .o_BRAM_Din   (o_BRAM_Din),
        .o_BRAM_En    (o_BRAM_En),
        .o_BRAM_WrEn  (o_BRAM_WrEn),
        .i_DpValid    (i_DpValid),
        .o_DpReady    (o_DpReady),
        .o_DpValid    (o_DpValid)
    );

    typedef struct {
        logic [RW-1:0] k;
        int            c;
        int            exp;
    } probe_t;

    probe_t probes[10];
    int     cap[0:VW];
    int     n_checks = 0;
    int     n_fail   = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Reference: smallest integer >= c*K/2^12, clamped to the entry range
    function automatic int model_entry(input int k, input int c);
        longint p;
        longint q;
        p = longint'(c) * longint'(k);
        q = p / 4096;
        if ((p % 4096) != 0) q = q + 1;
        if (q > EMAX) q = EMAX;
        return int'(q);
    endfunction

    // Watch one pass from the current negedge; optional start injection or reset at a given address
    task automatic capture(input int inj_addr, input logic [RW-1:0] inj_k, input int rst_addr,
                           output int nwr, output int first_wr, output int done_cyc,
                           output int order_err, output int busy1, output int leak);
        int a;
        nwr = 0; first_wr = -1; done_cyc = -1; order_err = 0; busy1 = -1; leak = 0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clk);
            i_CfgStart = 1'b0;
            if (cyc == 1) busy1 = int'(o_CfgBusy);
            if (o_DpValid) leak++;
            if (o_BRAM_WrEn) begin
                a = int'(o_BRAM_Addr);
                if (first_wr < 0) first_wr = cyc;
                if (a != nwr) order_err++;
                if (a <= VW) cap[a] = int'(o_BRAM_Din);
                nwr++;
                if (a == inj_addr) begin
                    i_CfgStart = 1'b1;
                    i_CfgRatio = inj_k;
                end
                if (a == rst_addr) begin
                    rst = 1'b1;
                    return;
                end
            end
            if (o_CfgDone) begin
                done_cyc = cyc;
                return;
            end
        end
    endtask

    task automatic clear_cap();
        for (int c = 0; c <= VW; c++) cap[c] = -1;
    endtask

    task automatic check_table(input logic [RW-1:0] k);
        int errs;
        int first_bad;
        errs = 0; first_bad = -1;
        for (int c = 0; c <= VW; c++) begin
            if (cap[c] != model_entry(int'(k), c)) begin
                errs++;
                if (first_bad < 0) first_bad = c;
            end
        end
        check($sformatf("table K=0x%04h bad entries (first bad c=%0d)", k, first_bad), errs, 0);
        for (int i = 0; i < 10; i++) begin
            if (probes[i].k == k)
                check($sformatf("probe K=0x%04h entry[%0d]", k, probes[i].c), cap[probes[i].c], probes[i].exp);
        end
    endtask

    task automatic check_pass(input string nm, input int nwr, input int first_wr, input int done_cyc,
                              input int order_err, input int busy1, input int leak);
        check({nm, " busy after start"}, busy1, 1);
        check({nm, " first write cycle"}, first_wr, 1 + DC);
        check({nm, " done cycle"}, done_cyc, LAT);
        check({nm, " write count"}, nwr, VW + 1);
        check({nm, " address order errors"}, order_err, 0);
        check({nm, " datapath valid leaks"}, leak, 0);
    endtask

    // Start a load from IDLE and verify the whole pass plus the idle state after it
    task automatic full_load(input logic [RW-1:0] k);
        int nwr, first_wr, done_cyc, order_err, busy1, leak;
        string nm;
        nm = $sformatf("load K=0x%04h", k);
        clear_cap();
        i_CfgStart = 1'b1;
        i_CfgRatio = k;
        capture(-1, '0, -1, nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_pass(nm, nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_table(k);
        @(negedge clk);
        check({nm, " done pulse width"}, int'(o_CfgDone), 0);
        check({nm, " busy after done"}, int'(o_CfgBusy), 0);
        check({nm, " table valid"}, int'(o_TableValid), 1);
        check({nm, " dp ready"}, int'(o_DpReady), 1);
        check({nm, " dp valid passthrough"}, int'(o_DpValid), 1);
    endtask

    initial begin
        int nwr, first_wr, done_cyc, order_err, busy1, leak, wr_after;
        logic [RW-1:0] k;

        probes[0] = '{16'h2000,   0,    0};
        probes[1] = '{16'h2000,   1,    2};
        probes[2] = '{16'h2000, 920, 1840};
        probes[3] = '{16'h1555,   1,    2};
        probes[4] = '{16'h1555,   3,    4};
        probes[5] = '{16'h3000, 682, 2046};
        probes[6] = '{16'h3000, 683, 2047};
        probes[7] = '{16'h3000, 920, 2047};
        probes[8] = '{16'h0000, 920,    0};
        probes[9] = '{16'h0000,   1,    0};

        rst = 1'b1; i_CfgStart = 1'b0; i_CfgRatio = '0; i_DpValid = 1'b0;
        repeat (3) @(negedge clk);
        check("reset busy", int'(o_CfgBusy), 0);
        check("reset bram_en", int'(o_BRAM_En), 1);
        check("reset wren", int'(o_BRAM_WrEn), 0);
        check("reset addr", int'(o_BRAM_Addr), 0);
        rst = 1'b0;
        i_DpValid = 1'b1;
        @(negedge clk);
        check("idle table valid", int'(o_TableValid), 0);
        check("idle dp ready", int'(o_DpReady), 0);
        check("idle wren", int'(o_BRAM_WrEn), 0);
        check("idle din", int'(o_BRAM_Din), 0);
        check("idle done", int'(o_CfgDone), 0);
        check("idle dropped", int'(o_CfgDropped), 0);
        check("idle dp valid blocked", int'(o_DpValid), 0);

        full_load(16'h2000);
        check("dropped after clean load", int'(o_CfgDropped), 0);
        i_DpValid = 1'b0;
        @(negedge clk);
        check("dp valid low input", int'(o_DpValid), 0);
        i_DpValid = 1'b1;

        full_load(16'h1555);
        full_load(16'h3000);
        full_load(16'h0000);
        full_load(16'hFFFF);
        for (int i = 0; i < 3; i++) begin
            k = RW'($urandom_range(65535, 0));
            full_load(k);
        end

        // Reset in the middle of a pass
        clear_cap();
        i_CfgStart = 1'b1;
        i_CfgRatio = 16'h2000;
        capture(-1, '0, 400, nwr, first_wr, done_cyc, order_err, busy1, leak);
        check("mid-load reset writes before reset", nwr, 401);
        @(negedge clk);
        check("mid-load reset busy", int'(o_CfgBusy), 0);
        check("mid-load reset wren", int'(o_BRAM_WrEn), 0);
        check("mid-load reset table valid", int'(o_TableValid), 0);
        check("mid-load reset dp ready", int'(o_DpReady), 0);
        rst = 1'b0;
        @(negedge clk);
        full_load(16'h1555);

        // Start request arriving while a load is in progress
        clear_cap();
        i_CfgStart = 1'b1;
        i_CfgRatio = 16'h2000;
        capture(100, 16'h3000, -1, nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_pass("busy-start first load", nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_table(16'h2000);
`ifdef CMP_LOADER_CFG_QUEUE_EN
        clear_cap();
        capture(-1, '0, -1, nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_pass("queued second load", nwr, first_wr, done_cyc, order_err, busy1, leak);
        check_table(16'h3000);
        @(negedge clk);
        check("queued table valid", int'(o_TableValid), 1);
        check("queued dropped", int'(o_CfgDropped), 0);
`else
        @(negedge clk);
        check("dropped flag", int'(o_CfgDropped), 1);
        check("dropped table valid", int'(o_TableValid), 1);
        wr_after = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (o_BRAM_WrEn) wr_after++;
        end
        check("writes after dropped start", wr_after, 0);
        check("dropped stays idle", int'(o_CfgBusy), 0);
        check("dropped flag sticky", int'(o_CfgDropped), 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
